// File: rtl/pixel_unpacker_if.sv
// rtl/pixel_unpacker_if.sv - word input, pixel output and control bundle for pixel_unpacker
interface pixel_unpacker_if #(
  parameter int IN_W = 32
);
  logic [1:0]      fmt;
  logic [IN_W-1:0] in_data;
  logic            input_valid;
  logic            strobe_input;
  logic            align;
  logic [23:0]     out24;
  logic            out24_ready;
  logic            strobe_out24;

  modport master (
    output fmt, in_data, input_valid, align, strobe_out24,
    input  strobe_input, out24, out24_ready
  );

  modport slave (
    input  fmt, in_data, input_valid, align, strobe_out24,
    output strobe_input, out24, out24_ready
  );
endinterface

// File: rtl/pixel_unpacker.sv
// rtl/pixel_unpacker.sv - pull-based gearbox from IN_W-bit words to 24-bit RGB pixels
// Line alignment (align input) is built only when PIXEL_UNPACKER_ALIGN_EN is defined.
module pixel_unpacker #(
  parameter int IN_W = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  pixel_unpacker_if.slave bus
);
  localparam int BW = IN_W + 32;
  localparam int LW = $clog2(BW);

  logic [BW-1:0] r_buf;
  logic [LW-1:0] r_lvl;
  logic [23:0]   r_out24;
  logic          r_ready;

  logic [LW-1:0] w_bpp;
  logic          w_need;
  logic          w_slot_free;
  logic          w_block;
  logic          w_update;
  logic          w_fetch;
  logic [BW-1:0] w_word_ext;
  logic [BW-1:0] w_work;
  logic [31:0]   w_top;
  logic [23:0]   w_pix;
  logic [BW-1:0] w_buf_next;
  logic [LW-1:0] w_lvl_next;

  always_comb begin
    w_bpp = LW'(8);
    case (bus.fmt)
      2'd0:    w_bpp = LW'(24);
      2'd1:    w_bpp = LW'(32);
      2'd2:    w_bpp = LW'(16);
      default: w_bpp = LW'(8);
    endcase
  end

  assign w_need      = r_lvl < w_bpp;
  assign w_slot_free = !r_ready || bus.strobe_out24;

`ifdef PIXEL_UNPACKER_ALIGN_EN
  assign w_block = i_reset || bus.align;
`else
  assign w_block = i_reset;
  logic w_unused_align;
  assign w_unused_align = bus.align;
`endif

  assign w_update         = !w_block && w_slot_free && (!w_need || bus.input_valid);
  assign w_fetch          = w_update && w_need;
  assign bus.strobe_input = w_fetch;

  // Bits of r_buf below r_lvl are always zero, so the new word can be OR-ed in.
  assign w_word_ext = {bus.in_data, 32'b0} >> r_lvl;
  assign w_work     = w_fetch ? (r_buf | w_word_ext) : r_buf;
  assign w_top      = w_work[BW-1 -: 32];

  always_comb begin
    w_pix = 24'd0;
    case (bus.fmt)
      2'd0:    w_pix = w_top[31:8];
      2'd1:    w_pix = w_top[23:0];
      2'd2:    w_pix = {w_top[31:27], w_top[31:29],
                        w_top[26:21], w_top[26:25],
                        w_top[20:16], w_top[20:18]};
      default: w_pix = {3{w_top[31:24]}};
    endcase
  end

  assign w_buf_next = w_work << w_bpp;
  assign w_lvl_next = r_lvl + (w_fetch ? LW'(IN_W) : LW'(0)) - w_bpp;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_buf   <= '0;
      r_lvl   <= '0;
      r_out24 <= '0;
      r_ready <= 1'b0;
    end else begin
`ifdef PIXEL_UNPACKER_ALIGN_EN
      // A presented pixel survives align; only the residual bits are dropped.
      if (bus.align) begin
        r_buf <= '0;
        r_lvl <= '0;
        if (bus.strobe_out24) r_ready <= 1'b0;
      end else
`endif
      if (w_update) begin
        r_buf   <= w_buf_next;
        r_lvl   <= w_lvl_next;
        r_out24 <= w_pix;
        r_ready <= 1'b1;
      end else if (bus.strobe_out24) begin
        r_ready <= 1'b0;
      end
    end
  end

  assign bus.out24       = r_out24;
  assign bus.out24_ready = r_ready;
endmodule

// File: tb/tb_pixel_unpacker.sv
// tb/tb_pixel_unpacker.sv - self-checking bench for pixel_unpacker with a bit-queue reference model
module tb_pixel_unpacker;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pixel_unpacker_if #(.IN_W(32)) u32 ();
  pixel_unpacker_if #(.IN_W(64)) u64 ();

  pixel_unpacker #(.IN_W(32)) dut32 (.i_clk(clk), .i_reset(reset), .bus(u32));
  pixel_unpacker #(.IN_W(64)) dut64 (.i_clk(clk), .i_reset(reset), .bus(u64));

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] g_words[$];
  logic [23:0] g_exp[$];
  int g_cycles;
  int g_si;

  function automatic int bpp_of(input logic [1:0] f);
    case (f)
      2'd0:    return 24;
      2'd1:    return 32;
      2'd2:    return 16;
      default: return 8;
    endcase
  endfunction

  function automatic logic [23:0] expand(input logic [1:0] f, input int p);
    int r, g, b;
    case (f)
      2'd0, 2'd1: return p[23:0];
      2'd2: begin
        r = (p >> 11) & 31;
        g = (p >> 5) & 63;
        b = p & 31;
        return 24'((((r << 3) | (r >> 2)) << 16) | (((g << 2) | (g >> 4)) << 8) | ((b << 3) | (b >> 2)));
      end
      default: return 24'((p & 255) * 32'h010101);
    endcase
  endfunction

  task automatic build_exp(input logic [1:0] f, input int w);
    bit q[$];
    int p;
    int bpp = bpp_of(f);
    g_exp.delete();
    foreach (g_words[i])
      for (int b = w - 1; b >= 0; b--) q.push_back(g_words[i][b]);
    while (q.size() >= bpp) begin
      p = 0;
      for (int k = 0; k < bpp; k++) p = (p << 1) | int'(q.pop_front());
      g_exp.push_back(expand(f, p));
    end
  endtask

  task automatic idle_inputs();
    u32.fmt = 2'd0; u32.in_data = '0; u32.input_valid = 1'b0; u32.align = 1'b0; u32.strobe_out24 = 1'b0;
    u64.fmt = 2'd0; u64.in_data = '0; u64.input_valid = 1'b0; u64.align = 1'b0; u64.strobe_out24 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic feed32(input logic [1:0] f, input int vprob, input int sprob);
    int idx = 0;
    int gi = 0;
    int avail = 0;
    int bpp = bpp_of(f);
    logic slot, exp_si;
    g_cycles = 0;
    g_si = 0;
    u32.fmt = f;
    while (gi < g_exp.size() && g_cycles < 3000) begin
      u32.in_data      = (idx < g_words.size()) ? g_words[idx][31:0] : 32'($urandom);
      u32.input_valid  = (idx < g_words.size()) && ($urandom_range(0, 99) < vprob);
      u32.strobe_out24 = u32.out24_ready && ($urandom_range(0, 99) < sprob);
      #1;
      slot   = !u32.out24_ready || u32.strobe_out24;
      exp_si = slot && u32.input_valid && (avail < bpp);
      n_total++;
      if (u32.strobe_input !== exp_si)
        $display("FAIL strobe_input fmt=%0d cycle=%0d got=%b exp=%b", f, g_cycles, u32.strobe_input, exp_si);
      else n_pass++;
      if (u32.strobe_out24) begin
        n_total++;
        if (u32.out24 !== g_exp[gi])
          $display("FAIL pixel fmt=%0d idx=%0d got=%h exp=%h", f, gi, u32.out24, g_exp[gi]);
        else n_pass++;
        gi++;
      end
      if (slot && (avail >= bpp || u32.input_valid))
        avail = avail + ((avail < bpp) ? 32 : 0) - bpp;
      if (exp_si) begin
        idx++;
        g_si++;
      end
      g_cycles++;
      @(posedge clk); #1;
    end
    u32.input_valid = 1'b0;
    u32.strobe_out24 = 1'b0;
    n_total++;
    if (gi != g_exp.size()) $display("FAIL feed32_timeout got=%0d pixels exp=%0d", gi, g_exp.size());
    else n_pass++;
  endtask

  task automatic run64(input logic [1:0] f);
    int idx = 0;
    int gi = 0;
    g_cycles = 0;
    g_si = 0;
    u64.fmt = f;
    while (gi < g_exp.size() && g_cycles < 200) begin
      u64.in_data      = (idx < g_words.size()) ? g_words[idx] : 64'd0;
      u64.input_valid  = idx < g_words.size();
      u64.strobe_out24 = u64.out24_ready;
      #1;
      if (u64.strobe_input) begin
        idx++;
        g_si++;
      end
      if (u64.strobe_out24) begin
        n_total++;
        if (u64.out24 !== g_exp[gi])
          $display("FAIL pixel64 fmt=%0d idx=%0d got=%h exp=%h", f, gi, u64.out24, g_exp[gi]);
        else n_pass++;
        gi++;
      end
      g_cycles++;
      @(posedge clk); #1;
    end
    u64.input_valid = 1'b0;
    u64.strobe_out24 = 1'b0;
    n_total++;
    if (gi != g_exp.size()) $display("FAIL run64_timeout got=%0d pixels exp=%0d", gi, g_exp.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    u32.input_valid = 1'b1;
    u32.in_data = 32'($urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++;
    if (u32.strobe_input !== 1'b0) $display("FAIL reset_strobe_input got=%b exp=0", u32.strobe_input);
    else n_pass++;
    n_total++;
    if (u32.out24 !== 24'd0 || u32.out24_ready !== 1'b0)
      $display("FAIL reset_out got=%h/%b exp=000000/0", u32.out24, u32.out24_ready);
    else n_pass++;
    n_total++;
    if (u64.out24 !== 24'd0 || u64.out24_ready !== 1'b0)
      $display("FAIL reset_out64 got=%h/%b exp=000000/0", u64.out24, u64.out24_ready);
    else n_pass++;
    reset = 1'b0;
    u32.input_valid = 1'b0;
    #1;
    n_total++;
    if (u32.strobe_input !== 1'b0 || u32.out24_ready !== 1'b0)
      $display("FAIL post_reset_idle got=%b/%b exp=0/0", u32.strobe_input, u32.out24_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_24bpp();
    do_reset();
    g_words = '{64'h11223344, 64'h55667788, 64'h99AABBCC};
    g_exp   = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    feed32(2'd0, 100, 100);
    n_total++;
    if (g_si != 3) $display("FAIL fmt0_fetch_count got=%0d exp=3", g_si);
    else n_pass++;
    n_total++;
    if (g_cycles != 5) $display("FAIL fmt0_throughput got=%0d cycles exp=5", g_cycles);
    else n_pass++;
  endtask

  task automatic test_16bpp_8bpp();
    do_reset();
    g_words = '{64'hF80007E0};
    g_exp   = '{24'hFF0000, 24'h00FF00};
    feed32(2'd2, 100, 100);
    do_reset();
    g_words = '{64'h80FF0001};
    g_exp   = '{24'h808080, 24'hFFFFFF, 24'h000000, 24'h010101};
    feed32(2'd3, 100, 100);
    n_total++;
    if (g_si != 1) $display("FAIL fmt3_fetch_count got=%0d exp=1", g_si);
    else n_pass++;
  endtask

  task automatic test_in64();
    do_reset();
    g_words = '{64'hFF123456_00ABCDEF};
    g_exp   = '{24'h123456, 24'hABCDEF};
    run64(2'd1);
    n_total++;
    if (g_si != 1) $display("FAIL in64_fmt1_fetch_count got=%0d exp=1", g_si);
    else n_pass++;
    do_reset();
    g_words.delete();
    for (int i = 0; i < 3; i++) g_words.push_back({32'($urandom), 32'($urandom)});
    build_exp(2'd0, 64);
    n_total++;
    if (g_exp.size() != 8) $display("FAIL in64_model_count got=%0d exp=8", g_exp.size());
    else n_pass++;
    run64(2'd0);
    n_total++;
    if (g_si != 3) $display("FAIL in64_fmt0_fetch_count got=%0d exp=3", g_si);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    u32.fmt = 2'd0;
    u32.in_data = 32'h11223344;
    u32.input_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    u32.in_data = 32'h55667788;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (u32.out24 !== 24'h112233 || u32.out24_ready !== 1'b1 || u32.strobe_input !== 1'b0)
        $display("FAIL backpressure_hold cycle=%0d got=%h/%b/%b exp=112233/1/0",
                 i, u32.out24, u32.out24_ready, u32.strobe_input);
      else n_pass++;
      @(posedge clk); #1;
    end
    u32.strobe_out24 = 1'b1;
    #1;
    n_total++;
    if (u32.strobe_input !== 1'b1) $display("FAIL backpressure_release got=%b exp=1", u32.strobe_input);
    else n_pass++;
    @(posedge clk); #1;
    u32.strobe_out24 = 1'b0;
    u32.input_valid = 1'b0;
    #1;
    n_total++;
    if (u32.out24 !== 24'h445566 || u32.out24_ready !== 1'b1)
      $display("FAIL backpressure_next got=%h/%b exp=445566/1", u32.out24, u32.out24_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_align();
    logic exp_si1, exp_si2;
    logic [23:0] exp_pix;
`ifdef PIXEL_UNPACKER_ALIGN_EN
    exp_si1 = 1'b0; exp_si2 = 1'b1; exp_pix = 24'hAABBCC;
`else
    exp_si1 = 1'b1; exp_si2 = 1'b0; exp_pix = 24'h44AABB;
`endif
    do_reset();
    u32.fmt = 2'd0;
    u32.in_data = 32'h11223344;
    u32.input_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    u32.in_data = 32'hAABBCCDD;
    u32.align = 1'b1;
    u32.strobe_out24 = 1'b1;
    #1;
    n_total++;
    if (u32.strobe_input !== exp_si1) $display("FAIL align_cycle_strobe_input got=%b exp=%b", u32.strobe_input, exp_si1);
    else n_pass++;
    @(posedge clk); #1;
    u32.align = 1'b0;
    u32.strobe_out24 = 1'b0;
    #1;
    n_total++;
    if (u32.strobe_input !== exp_si2) $display("FAIL align_refetch got=%b exp=%b", u32.strobe_input, exp_si2);
    else n_pass++;
    @(posedge clk); #1;
    u32.input_valid = 1'b0;
    #1;
    n_total++;
    if (u32.out24 !== exp_pix || u32.out24_ready !== 1'b1)
      $display("FAIL align_next_pixel got=%h/%b exp=%h/1", u32.out24, u32.out24_ready, exp_pix);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    u32.fmt = 2'd0;
    u32.in_data = 32'h11223344;
    u32.input_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    u32.in_data = 32'h55667788;
    u32.strobe_out24 = 1'b1;
    #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_total++;
    if (u32.strobe_input !== 1'b0) $display("FAIL midreset_strobe_input got=%b exp=0", u32.strobe_input);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    u32.input_valid = 1'b0;
    u32.strobe_out24 = 1'b0;
    #1;
    n_total++;
    if (u32.out24_ready !== 1'b0 || u32.out24 !== 24'd0)
      $display("FAIL midreset_cleared got=%h/%b exp=000000/0", u32.out24, u32.out24_ready);
    else n_pass++;
    g_words = '{64'h11223344};
    g_exp   = '{24'h112233};
    feed32(2'd0, 100, 100);
  endtask

  task automatic test_random();
    int n;
    for (int rep = 0; rep < 3; rep++) begin
      for (int f = 0; f < 4; f++) begin
        do_reset();
        n = (f == 0) ? 3 * $urandom_range(1, 4) : $urandom_range(2, 10);
        g_words.delete();
        for (int i = 0; i < n; i++) g_words.push_back(64'($urandom));
        build_exp(2'(f), 32);
        feed32(2'(f), $urandom_range(40, 100), $urandom_range(40, 100));
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_24bpp();
    test_16bpp_8bpp();
    test_in64();
    test_backpressure();
    test_align();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pixel_unpacker.md
# pixel_unpacker

Pull-based gearbox that extracts variable-size pixels from a stream of IN_W-bit memory words and presents them as 24-bit RGB.
- Generalises the fixed 32→24 converter: parametrised input width, a runtime pixel format (24/32/16/8 bpp) and optional line alignment.
- Sits between the framebuffer read FIFO and the video pixel pipeline, which pulls one pixel per strobe.

## Interface
- IN_W, 32, input word width; legal values 32 or 64.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fmt  in  2  pixel format:
  - 0: 24bpp packed.
  - 1: 32bpp XRGB; the low 24 bits are used.
  - 2: 16bpp RGB565.
  - 3: 8bpp grey.
- in_data  in  IN_W  input word.
- input_valid  in  1  in_data may be consumed.
- strobe_input  out  1  combinational; in_data consumed this cycle.
- align  in  1  drop buffered residual bits. Active only with PIXEL_UNPACKER_ALIGN_EN.
- out24  out  24  pixel, {R,G,B}.
- out24_ready  out  1  out24 holds a valid pixel.
- strobe_out24  in  1  consumer took out24. Legal only while out24_ready.

## Operation
- Bit buffer `buf`, IN_W+32 bits, MSB-aligned. Level counter `lvl` ranges 0..IN_W+31.
- bpp = 24/32/16/8 per fmt.
- Words are consumed MSB-first: the first pixel comes from the top bits of the first word.
- `slot_free` = !out24_ready || strobe_out24.
- `need` = lvl < bpp.
- `update`:
  - If need: slot_free && input_valid.
  - Otherwise: slot_free.
- `strobe_input` = update && need.
- On update:
  - Working vector W is buf, with in_data appended directly below bit lvl when fetching.
  - Pixel p = top bpp bits of W.
  - buf ← W shifted left by bpp.
  - lvl ← lvl + (fetch ? IN_W : 0) − bpp.
  - out24_ready ← 1.
- Strobe without update: if strobe_out24 and no update, out24_ready ← 0.
- Expansion of p to out24:
  - 24bpp: p.
  - 32bpp: p[23:0].
  - 16bpp: {p[15:11],p[15:13], p[10:5],p[10:9], p[4:0],p[4:2]}.
  - 8bpp: {p,p,p}.
- Pattern periods:
  - IN_W=32, 24bpp: 3 words yield 4 pixels; every 4th pixel is emitted without fetching.
  - IN_W=64, 24bpp: 3 words yield 8 pixels.
- fmt is sampled on each update. It must only change after reset or align; otherwise residual bits are reinterpreted. This is legal but undefined in content.

## Timing
- Reset values: out24=0, out24_ready=0, strobe_input=0 (given input_valid is a don't-care), lvl=0, buf=0.
- Latency: out24 and out24_ready update on the clock edge after the update cycle.
- Throughput: one pixel per clock when the consumer strobes every cycle and input_valid is held high.
- Backpressure: while out24_ready && !strobe_out24, out24 is stable and strobe_input=0. There is no prefetch.
- Starvation: if need && !input_valid, out24_ready falls after a strobe. State is retained and resumes without loss.
- Reset mid-stream:
  - Residual bits are discarded and out24_ready is cleared the next cycle.
  - strobe_input is 0 during a reset cycle.
- align (macro on):
  - In the cycle align=1: lvl←0, buf←0, update is suppressed and strobe_input=0.
  - A presented out24 stays valid; a strobe_out24 in that cycle still clears out24_ready.
  - Reset has priority over align.

## Configuration
- PIXEL_UNPACKER_ALIGN_EN defined:
  - align is honoured as above.
  - Used at line start so each scanline begins word-aligned regardless of line length × bpp.
- Undefined:
  - align is ignored; no logic is generated for it.
  - Residual bits always carry into the next line.

## Test plan
- IN_W=32, fmt=0, words 0x11223344, 0x55667788, 0x99AABBCC, strobe every cycle:
  - Output is 0x112233, 0x445566, 0x778899, 0xAABBCC.
  - strobe_input pulses exactly 3 times; the 4th pixel is emitted with strobe_input=0.
- IN_W=64, fmt=1, word 0xFF123456_00ABCDEF:
  - Output is 0x123456 then 0xABCDEF; one strobe_input.
- IN_W=32:
  - fmt=2, word 0xF80007E0 → 0xFF0000, 0x00FF00.
  - fmt=3, word 0x80FF0001 → 0x808080, 0xFFFFFF, 0x000000, 0x010101.
- Backpressure, fmt=0: no strobe_out24 for 5 cycles with input_valid=1:
  - out24 stays 0x112233 and strobe_input=0 throughout.
  - After a single strobe, 0x445566 appears next cycle.
- Align, fmt=0, after 1 pixel of 0x11223344, then word 0xAABBCCDD:
  - Macro on, align pulsed: next pixel 0xAABBCC.
  - Macro off: next pixel 0x44AABB.
- Reset asserted with lvl=16, then word 0x11223344:
  - out24_ready=0 after reset.
  - First pixel after reset is 0x112233.
